// File: rtl/mfp_ahb_irq_ctrl.sv
// AHB-Lite interrupt controller: per-channel level/edge mode, mask, sticky W1C pending and a
// priority-encoded active ID. Define MFP_IRQ_SYNC_EN to add a 2-flop synchroniser on IRQ_IN.
module mfp_ahb_irq_ctrl #(
    parameter int N_IRQ    = 8,
    parameter int N_SI_INT = 8
) (
    input  logic                HCLK,
    input  logic                SI_Reset,
    input  logic                HSEL,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic                HREADY,
    input  logic [31:0]         HWDATA,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    output logic                HRESP,
    input  logic [N_IRQ-1:0]    IRQ_IN,
    output logic [N_SI_INT-1:0] SI_Int,
    output logic [N_IRQ-1:0]    IRQ_ACTIVE
);

    localparam logic [2:0] OFF_RAW       = 3'd0;
    localparam logic [2:0] OFF_PENDING   = 3'd1;
    localparam logic [2:0] OFF_MASK      = 3'd2;
    localparam logic [2:0] OFF_EDGE      = 3'd3;
    localparam logic [2:0] OFF_ACTIVE_ID = 3'd4;

    logic             dp_valid_r;
    logic             dp_write_r;
    logic [2:0]       dp_addr_r;
    logic             addr_ph_s;
    logic             wr_s;
    logic             pend_we_s;
    logic             mask_we_s;
    logic             edge_we_s;
    logic [N_IRQ-1:0] irq_s;
    logic [N_IRQ-1:0] irq_prev_r;
    logic [N_IRQ-1:0] rise_s;
    logic [N_IRQ-1:0] w1c_s;
    logic [N_IRQ-1:0] pending_r;
    logic [N_IRQ-1:0] pending_nxt_s;
    logic [N_IRQ-1:0] mask_r;
    logic [N_IRQ-1:0] edge_r;
    logic [N_IRQ-1:0] active_s;
    logic             any_active_s;
    logic [4:0]       active_id_s;
    logic [31:0]      rdata_s;
    logic [N_SI_INT-1:0] si_int_s;
    logic             unused_s;

    // Zero-extend a channel vector to a bus word; bits above N_IRQ-1 read 0.
    function automatic logic [31:0] zext(input logic [N_IRQ-1:0] v);
        logic [31:0] w;
        w = 32'h0;
        w[N_IRQ-1:0] = v;
        return w;
    endfunction

`ifdef MFP_IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_r;
    logic [N_IRQ-1:0] sync2_r;

    // Two-flop synchroniser for sources outside the HCLK domain.
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= IRQ_IN;
            sync2_r <= sync1_r;
        end
    end

    assign irq_s = sync2_r;
`else
    assign irq_s = IRQ_IN;
`endif

    assign addr_ph_s = HSEL & HTRANS[1] & HREADY;
    assign wr_s      = dp_valid_r & dp_write_r & HREADY;
    assign rise_s    = irq_s & ~irq_prev_r;

    // Latch the accepted address phase; an idle cycle with HREADY high closes the data phase.
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_addr_r  <= 3'd0;
        end else if (HREADY) begin
            dp_valid_r <= addr_ph_s;
            dp_write_r <= HWRITE;
            dp_addr_r  <= HADDR[4:2];
        end
    end

    // Register write decode for the data phase that ends on this edge.
    always_comb begin
        pend_we_s = 1'b0;
        mask_we_s = 1'b0;
        edge_we_s = 1'b0;
        if (wr_s) begin
            case (dp_addr_r)
                OFF_PENDING: pend_we_s = 1'b1;
                OFF_MASK:    mask_we_s = 1'b1;
                OFF_EDGE:    edge_we_s = 1'b1;
                default: begin
                    pend_we_s = 1'b0;
                    mask_we_s = 1'b0;
                    edge_we_s = 1'b0;
                end
            endcase
        end else begin
            pend_we_s = 1'b0;
        end
    end

    assign w1c_s = pend_we_s ? HWDATA[N_IRQ-1:0] : '0;

    // Pending next state: level channels track the input, edge channels are sticky and set beats clear.
    always_comb begin
        pending_nxt_s = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (edge_r[i]) begin
                pending_nxt_s[i] = rise_s[i] | (pending_r[i] & ~w1c_s[i]);
            end else begin
                pending_nxt_s[i] = irq_s[i];
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            pending_r  <= '0;
            mask_r     <= '0;
            edge_r     <= '0;
            irq_prev_r <= '0;
        end else begin
            pending_r  <= pending_nxt_s;
            irq_prev_r <= irq_s;
            if (mask_we_s) begin
                mask_r <= HWDATA[N_IRQ-1:0];
            end
            if (edge_we_s) begin
                edge_r <= HWDATA[N_IRQ-1:0];
            end
        end
    end

    assign active_s     = pending_r & mask_r;
    assign any_active_s = |active_s;

    // Lowest-numbered active channel wins; scanning downward lets the lowest index overwrite last.
    always_comb begin
        active_id_s = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active_s[i]) begin
                active_id_s = 5'(i);
            end else begin
                active_id_s = active_id_s;
            end
        end
    end

    // Read mux, driven only while a read data phase is open.
    always_comb begin
        rdata_s = 32'h0;
        if (dp_valid_r && !dp_write_r) begin
            case (dp_addr_r)
                OFF_RAW:       rdata_s = zext(irq_s);
                OFF_PENDING:   rdata_s = zext(pending_r);
                OFF_MASK:      rdata_s = zext(mask_r);
                OFF_EDGE:      rdata_s = zext(edge_r);
                OFF_ACTIVE_ID: rdata_s = {any_active_s, 26'h0, active_id_s};
                default:       rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    // Core interrupt vector: only bit 0 is used.
    always_comb begin
        si_int_s    = '0;
        si_int_s[0] = any_active_s;
    end

    assign HRDATA     = rdata_s;
    assign HREADYOUT  = 1'b1;
    assign HRESP      = 1'b0;
    assign SI_Int     = si_int_s;
    assign IRQ_ACTIVE = active_s;

    // Address bits outside [4:2], HTRANS[0] and upper write-data bits are intentionally ignored.
    assign unused_s = ^{HADDR, HTRANS, HWDATA};

endmodule
